// File: rtl/ntt_bitrev_reorder_pkg.sv
// Shared constants, types and the index bit-reversal helper for the
// NTT natural-order reorder buffer.
package ntt_bitrev_reorder_pkg;

    localparam int NTT_W     = 32;
    localparam int MODULUS   = 7681;
    localparam int NTT_RADIX = 16;
    localparam int NTT_LOG2N = $clog2(NTT_RADIX);

    typedef logic [NTT_W-1:0] coef_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

    function automatic logic [31:0] bitrev(
        input logic [31:0] idx,
        input int unsigned nbits
    );
        logic [31:0] r;
        logic [4:0]  j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(nbits)) begin
                j    = 5'(int'(nbits) - 1 - i);
                r[i] = idx[j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_bitrev_reorder_pingpong_bank.sv
// Two RADIX-word banks of registers: one write port, one asynchronous
// read port, each addressed by {bank select, word address}.
module ntt_bitrev_reorder_pingpong_bank #(
    parameter int W          = 32,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          wsel_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          rsel_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [2*DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wsel_i, waddr_i}] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[{rsel_i, raddr_i}];

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// Buffers bit-reversed NTT output frames in a ping-pong bank pair and
// replays each frame in natural order over a valid/ready interface.
module ntt_bitrev_reorder
    import ntt_bitrev_reorder_pkg::*;
#(
    parameter int  W     = NTT_W,
    parameter int  RADIX = NTT_RADIX,
    localparam int LOG2N = $clog2(RADIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [W-1:0]     in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_sof,
    output logic             out_eof,
    output logic             overrun,
    output logic             sof_err
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(RADIX - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    wr_state_e        state_q, state_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_sel_q, wr_sel_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       full_q, full_d;
    logic             overrun_q, overrun_d;
    logic             sof_err_q, sof_err_d;

    logic             rd_fire;
    logic             rd_release;
    logic             bank_free;
    logic             wr_last;
    logic             we;
    logic [LOG2N-1:0] waddr;
    logic             set_full;
    logic             set_overrun;
    logic             set_sof_err;

    // ------------------------------------------------------------ reader
    assign out_valid  = full_q[rd_sel_q];
    assign out_idx    = rd_cnt_q;
    assign out_sof    = out_valid && (rd_cnt_q == '0);
    assign out_eof    = out_valid && (rd_cnt_q == LAST);
    assign rd_fire    = out_valid && out_ready;
    assign rd_release = rd_fire && (rd_cnt_q == LAST);

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        rd_sel_d = rd_sel_q;
        if (rd_release) begin
            rd_cnt_d = '0;
            rd_sel_d = ~rd_sel_q;
        end else if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            rd_sel_q <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // ------------------------------------------------------------ writer
    // A bank being released by the reader this edge counts as free, so
    // back-to-back frames never see a spurious overrun.
    assign bank_free = !full_q[wr_sel_q]
                    || (rd_release && (rd_sel_q == wr_sel_q));
    assign wr_last   = (wr_cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WR_IDLE;
            wr_cnt_q  <= '0;
            wr_sel_q  <= 1'b0;
            full_q    <= 2'b00;
            overrun_q <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_sel_q  <= wr_sel_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            sof_err_q <= sof_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        wr_sel_d = wr_sel_q;
        if (in_valid) begin
            unique case (state_q)
                WR_IDLE, WR_DROP: begin
                    if (in_sof) begin
                        state_d  = bank_free ? WR_FILL : WR_DROP;
                        wr_cnt_d = ONE;
                    end else if (state_q == WR_DROP) begin
                        if (wr_last) begin
                            state_d  = WR_IDLE;
                            wr_cnt_d = '0;
                        end else begin
                            wr_cnt_d = wr_cnt_q + ONE;
                        end
                    end
                end
                WR_FILL: begin
                    if (in_sof) begin
                        wr_cnt_d = ONE;
                    end else if (wr_last) begin
                        state_d  = WR_IDLE;
                        wr_cnt_d = '0;
                        wr_sel_d = ~wr_sel_q;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ONE;
                    end
                end
                default: begin
                    state_d  = WR_IDLE;
                    wr_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        we          = 1'b0;
        waddr       = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
        set_full    = 1'b0;
        set_overrun = 1'b0;
        set_sof_err = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                WR_IDLE, WR_DROP: begin
                    if (in_sof) begin
                        waddr       = '0;
                        we          = bank_free;
                        set_overrun = !bank_free;
                    end else if (state_q == WR_IDLE) begin
                        set_sof_err = 1'b1;
                    end
                end
                WR_FILL: begin
                    we = 1'b1;
                    if (in_sof) begin
                        waddr       = '0;
                        set_sof_err = 1'b1;
                    end else begin
                        set_full = wr_last;
                    end
                end
                default: begin
                    we = 1'b0;
                end
            endcase
        end
    end

    // Release and fill always target different banks, so order is moot.
    always_comb begin
        full_d = full_q;
        if (rd_release) begin
            full_d[rd_sel_q] = 1'b0;
        end
        if (set_full) begin
            full_d[wr_sel_q] = 1'b1;
        end
    end

    assign overrun_d = overrun_q | set_overrun;
    assign sof_err_d = sof_err_q | set_sof_err;
    assign overrun   = overrun_q;
    assign sof_err   = sof_err_q;

    // ------------------------------------------------------------ storage
    ntt_bitrev_reorder_pingpong_bank #(
        .W     (W),
        .DEPTH (RADIX)
    ) u_bank (
        .clk_i   (clk),
        .we_i    (we),
        .wsel_i  (wr_sel_q),
        .waddr_i (waddr),
        .wdata_i (in_data),
        .rsel_i  (rd_sel_q),
        .raddr_i (rd_cnt_q),
        .rdata_o (out_data)
    );

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Randomized self-checking bench for ntt_bitrev_reorder against a
// frame-level reference model (two-frame capacity, natural-order replay).
module tb_ntt_bitrev_reorder;
    import ntt_bitrev_reorder_pkg::*;

    localparam int N  = 16;
    localparam int LG = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    coef_t         in_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    coef_t         out_data;
    logic [LG-1:0] out_idx;
    logic          out_sof;
    logic          out_eof;
    logic          overrun;
    logic          sof_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ntt_bitrev_reorder #(.W(32), .RADIX(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .overrun   (overrun),
        .sof_err   (sof_err)
    );

    // monitor: accepted words, stall stability, sof/eof flag consistency
    coef_t obs_d[$];
    int    obs_i[$];
    int    obs_cyc[$];
    int    cyc = 0;
    int    stall_viol = 0;
    int    flag_viol = 0;
    logic  prev_stall = 1'b0;
    coef_t prev_d;
    logic [LG-1:0] prev_i;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (out_sof !== (out_valid && out_idx == 4'd0)) flag_viol++;
            if (out_eof !== (out_valid && out_idx == 4'd15)) flag_viol++;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_d
                               || out_idx !== prev_i)) stall_viol++;
            if (out_valid === 1'b1 && out_ready) begin
                obs_d.push_back(out_data);
                obs_i.push_back(int'(out_idx));
                obs_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_i     = out_idx;
        end
    end

    // reference model
    int    occ;
    int    mstate;
    int    mcnt;
    coef_t nat [N];
    logic  m_overrun;
    logic  m_sof_err;
    coef_t exp_d[$];
    int    exp_i[$];
    int    base;
    int    sv0;
    int    fv0;

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < LG; b++) begin
            if ((k >> b) & 1) r = r | (1 << (LG - 1 - b));
        end
        return r;
    endfunction

    function automatic logic rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic model_reset();
        occ       = 0;
        mstate    = 0;
        mcnt      = 0;
        m_overrun = 1'b0;
        m_sof_err = 1'b0;
        exp_d.delete();
        exp_i.delete();
        base = obs_d.size();
        sv0  = stall_viol;
        fv0  = flag_viol;
    endtask

    task automatic drive_cycle(input logic v, input logic s,
                               input coef_t d, input logic r);
        logic pop;
        logic done;
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = r;
        pop  = r && occ > 0;
        done = 1'b0;
        if (v) begin
            if (s && mstate != 1) begin
                mcnt = 1;
                if ((occ - int'(pop) + N - 1) / N < 2) begin
                    mstate = 1;
                    nat[0] = d;
                end else begin
                    mstate    = 2;
                    m_overrun = 1'b1;
                end
            end else if (s) begin
                m_sof_err = 1'b1;
                mcnt      = 1;
                nat[0]    = d;
            end else if (mstate == 0) begin
                m_sof_err = 1'b1;
            end else begin
                if (mstate == 1) nat[rev(mcnt)] = d;
                if (mcnt == N - 1) begin
                    done   = (mstate == 1);
                    mstate = 0;
                    mcnt   = 0;
                end else begin
                    mcnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (pop) occ--;
        if (done) begin
            occ += N;
            for (int i = 0; i < N; i++) begin
                exp_d.push_back(nat[i]);
                exp_i.push_back(i);
            end
        end
    endtask

    task automatic idle(input int n, input int rdy_pct);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, rnd(rdy_pct));
    endtask

    task automatic send_frame(input coef_t x [N], input int gap_pct,
                              input int rdy_pct);
        for (int k = 0; k < N; k++) begin
            while (rnd(gap_pct)) drive_cycle(1'b0, 1'b0, '0, rnd(rdy_pct));
            drive_cycle(1'b1, k == 0, x[rev(k)], rnd(rdy_pct));
        end
    endtask

    task automatic rand_frame(output coef_t x [N]);
        for (int i = 0; i < N; i++) x[i] = $urandom;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0b want 0", out_valid);
        end
        checks++;
        if (out_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_idx got %0d want 0", out_idx);
        end
        checks++;
        if (overrun !== 1'b0 || sof_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %0b%0b want 00", overrun, sof_err);
        end
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_valid got %0b want 0", out_valid);
                end
            end
            drive_cycle(1'b1, k == 0, coef_t'(100 + rev(k)), 1'b1);
        end
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_sof !== 1'b1
            || out_data !== coef_t'(100)) begin
            errors++;
            $display("FAIL latency got v=%0b idx=%0d d=%0d want v=1 idx=0 d=100",
                     out_valid, out_idx, out_data);
        end
        idle(20, 100);
        checks++;
        if (obs_d.size() - base != N) begin
            errors++;
            $display("FAIL single_count got %0d want 16", obs_d.size() - base);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_d[base+i] !== coef_t'(100 + i) || obs_i[base+i] != i) begin
                    errors++;
                    $display("FAIL single_word%0d got %0d@%0d want %0d@%0d",
                             i, obs_d[base+i], obs_i[base+i], 100 + i, i);
                end
            end
        end
        checks++;
        if (flag_viol != fv0) begin
            errors++;
            $display("FAIL single_sof_eof got %0d want 0", flag_viol - fv0);
        end
    endtask

    task automatic test_back_to_back();
        coef_t x [N];
        int gaps;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            rand_frame(x);
            send_frame(x, 0, 100);
        end
        idle(40, 100);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun got %0b want 0", overrun);
        end
        checks++;
        if (obs_d.size() - base != 48 || exp_d.size() != 48) begin
            errors++;
            $display("FAIL b2b_count got %0d want 48", obs_d.size() - base);
        end else begin
            gaps = 0;
            for (int i = 0; i < 48; i++) begin
                checks++;
                if (obs_d[base+i] !== exp_d[i] || obs_i[base+i] != exp_i[i]) begin
                    errors++;
                    $display("FAIL b2b_word%0d got %0h@%0d want %0h@%0d",
                             i, obs_d[base+i], obs_i[base+i], exp_d[i], exp_i[i]);
                end
                if (obs_cyc[base+i] != obs_cyc[base] + i) gaps++;
            end
            checks++;
            if (gaps != 0) begin
                errors++;
                $display("FAIL b2b_bubbles got %0d want 0", gaps);
            end
        end
    endtask

    task automatic test_overrun();
        coef_t x [N];
        coef_t first;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            rand_frame(x);
            if (f == 0) first = x[0];
            send_frame(x, 0, 0);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag got %0b want 1", overrun);
        end
        idle(50, 100);
        checks++;
        if (obs_d.size() - base != 32 || exp_d.size() != 32) begin
            errors++;
            $display("FAIL ovr_count got %0d want 32", obs_d.size() - base);
        end else begin
            checks++;
            if (obs_d[base] !== first) begin
                errors++;
                $display("FAIL ovr_first got %0h want %0h", obs_d[base], first);
            end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (obs_d[base+i] !== exp_d[i] || obs_i[base+i] != exp_i[i]) begin
                    errors++;
                    $display("FAIL ovr_word%0d got %0h@%0d want %0h@%0d",
                             i, obs_d[base+i], obs_i[base+i], exp_d[i], exp_i[i]);
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive_cycle(1'b1, k == 0, coef_t'($urandom), 1'b1);
        end
        for (int k = 0; k < N; k++) begin
            drive_cycle(1'b1, k == 0, coef_t'(200 + rev(k)), 1'b1);
        end
        idle(20, 100);
        checks++;
        if (sof_err !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midsof_flags got err=%0b ovr=%0b want err=1 ovr=0",
                     sof_err, overrun);
        end
        checks++;
        if (obs_d.size() - base != N) begin
            errors++;
            $display("FAIL midsof_count got %0d want 16", obs_d.size() - base);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_d[base+i] !== coef_t'(200 + i) || obs_i[base+i] != i) begin
                    errors++;
                    $display("FAIL midsof_word%0d got %0d want %0d",
                             i, obs_d[base+i], 200 + i);
                end
            end
        end
    endtask

    task automatic test_random();
        coef_t x [N];
        int bad;
        apply_reset();
        for (int f = 0; f < 20; f++) begin
            rand_frame(x);
            send_frame(x, 50, 50);
            idle($urandom_range(3), 50);
        end
        idle(100, 100);
        checks++;
        if (obs_d.size() - base != exp_d.size()) begin
            errors++;
            $display("FAIL rand_count got %0d want %0d",
                     obs_d.size() - base, exp_d.size());
        end else begin
            bad = 0;
            for (int i = 0; i < exp_d.size(); i++) begin
                if (obs_d[base+i] !== exp_d[i] || obs_i[base+i] != exp_i[i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_words got %0d bad want 0", bad);
            end
        end
        checks++;
        if (stall_viol != sv0) begin
            errors++;
            $display("FAIL rand_stall got %0d want 0", stall_viol - sv0);
        end
        checks++;
        if (flag_viol != fv0) begin
            errors++;
            $display("FAIL rand_sof_eof got %0d want 0", flag_viol - fv0);
        end
        checks++;
        if (overrun !== m_overrun || sof_err !== m_sof_err) begin
            errors++;
            $display("FAIL rand_flags got %0b%0b want %0b%0b",
                     overrun, sof_err, m_overrun, m_sof_err);
        end
    endtask

    task automatic test_reset_mid();
        coef_t x [N];
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            rand_frame(x);
            send_frame(x, 0, 0);
        end
        idle(5, 100);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd5) begin
            errors++;
            $display("FAIL rstmid_pre got v=%0b idx=%0d want v=1 idx=5",
                     out_valid, out_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_async got v=%0b idx=%0d want v=0 idx=0",
                     out_valid, out_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rand_frame(x);
        send_frame(x, 0, 100);
        idle(20, 100);
        checks++;
        if (obs_d.size() - base != N) begin
            errors++;
            $display("FAIL rstmid_count got %0d want 16", obs_d.size() - base);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs_d[base+i] !== x[i] || obs_i[base+i] != i) begin
                    errors++;
                    $display("FAIL rstmid_word%0d got %0h want %0h",
                             i, obs_d[base+i], x[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_mid_sof();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
